fifo_pong_reader: RTL
=====================

# fifo_pong_reader

Frame-draining reader for the consumer side of the ping-pong FIFO. It pulls 32-bit words through the FIFO's guarded first/deq methods and parses them as length-prefixed frames. For each frame it accumulates a wrap-around checksum and emits one report transaction per frame toward the indication path. It is the consumer counterpart to the FIFO's enq/deq storage and sits between the FIFO and the host-indication logic.

## Interface
- MAX_LEN, 255: largest legal payload length. Larger headers are flagged as errors.
- CLK  in  1  single clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- src_first  in  32  head word of the upstream FIFO.
- src_first__RDY  in  1  src_first is valid.
- src_deq__ENA  out  1  dequeue strobe; the head word is consumed this cycle.
- src_deq__RDY  in  1  upstream can dequeue.
- report__ENA  out  1  report valid, held until accepted.
- report__RDY  in  1  downstream accepts the report.
- report_tag  out  16  tag field from the frame header.
- report_len  out  16  length field from the frame header.
- report_sum  out  32  mod-2^32 sum of the payload words.
- report_err  out  1  header length exceeded MAX_LEN.
- busy  out  1  a frame is in progress (state is not S_HDR).

## Operation
- Header word format: [31:16] tag, [15:0] len.
- The deq handshake fires on a cycle when src_deq__ENA is high.
- src_deq__ENA = nRST && (state==S_HDR || state==S_PAY) && src_first__RDY && src_deq__RDY.
  - It is never asserted in S_RPT.
  - The word on src_first is sampled on the same edge that the deq fires.
- FSM states: S_HDR, S_PAY, S_RPT.
- S_HDR, on deq:
  - Latch tag and len.
  - Clear sum and remaining count; load remaining = len.
  - Set err = (len > MAX_LEN).
  - If len==0, go to S_RPT; otherwise go to S_PAY.
- S_PAY, on deq:
  - If err==0, sum <= sum + word (wraps mod 2^32). If err==1, the word is discarded and sum stays 0.
  - Decrement remaining; when remaining reaches 0 after this deq, go to S_RPT.
  - The FSM stalls without side effects while src_first__RDY or src_deq__RDY is low.
- Oversize frames are still fully drained (len words), so stream alignment is preserved.
- S_RPT:
  - report__ENA=1 and the report_* outputs are stable.
  - On report__ENA && report__RDY, go to S_HDR.
  - Until then, report outputs hold and the FIFO is not touched.
- Report outputs are registered and hold their last value outside S_RPT.

## Timing
- Reset values: state=S_HDR; tag, len, sum, remaining, err = 0. All outputs are 0: src_deq__ENA, report__ENA, report_tag, report_len, report_sum, report_err, busy.
- Reset is asynchronous. Asserting it mid-frame abandons the frame, and no report is issued.
- Throughput: a len=N frame with no stalls takes 1 header cycle + N payload cycles + ≥1 report cycle, i.e. N+2 cycles minimum.
  - report__ENA rises in the cycle after the last deq.
- After report acceptance at edge k, the next header deq can fire no earlier than cycle k+1.
- len=0: report__ENA is asserted in the cycle after the header deq, with sum=0.
- len=MAX_LEN is legal (err=0); len=MAX_LEN+1 sets err=1.
- The remaining counter is 16 bits, and no wrap is possible because it is loaded from len.

## Structure
- Package fifo_pong_reader_pkg holds:
  - the state encoding (S_HDR/S_PAY/S_RPT);
  - header field positions (TAG_MSB=31, TAG_LSB=16, LEN_MSB=15, LEN_LSB=0);
  - width constants (DATA_W=32, LEN_W=16).
- One sub-module, frame_accumulator, holds the sum and remaining-count registers.
  - Inputs: load, add, word.
  - Outputs: sum, last.
- FSM and handshake logic stay in fifo_pong_reader.

## Test plan
- Basic frame: header 0x00AB_0003, payload 1, 2, 3, with no stalls.
  - Expect exactly 4 deqs, then report tag=0x00AB, len=3, sum=6, err=0, and report__ENA in cycle 5.
- Zero length and backpressure: header 0x0001_0000, with report__RDY held low for 5 cycles.
  - Expect report len=0, sum=0.
  - report__ENA stays high and stable, and no deq occurs until acceptance.
- Checksum wrap: header len=2, payload 0xFFFF_FFFF, 0x0000_0002. Expect sum=0x0000_0001.
- Oversize: MAX_LEN=255, header 0x0000_0100, then 256 payload words, then header 0x0002_0001 and payload 7.
  - First report: err=1, sum=0, len=256.
  - Second report: tag=2, len=1, sum=7, err=0, showing alignment is kept.
- Input stalls: toggle src_first__RDY every other cycle during a len=4 frame of payload 10, 20, 30, 40.
  - Expect sum=100, exactly 5 deqs, and no deq while src_first__RDY is low.
- Async reset: assert nRST after the second payload word of a len=4 frame, then release.
  - Expect outputs 0 immediately, no report, and the next word parsed as a header.

Source files
------------

// File: rtl/fifo_pong_reader_pkg.sv
// fifo_pong_reader shared types and constants.
// State encoding, header field positions and datapath widths.
package fifo_pong_reader_pkg;

    localparam int DATA_W  = 32;
    localparam int LEN_W   = 16;
    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 16;
    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 0;
    localparam int MAX_LEN_DEF = 255;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_PAY = 2'd1,
        S_RPT = 2'd2
    } state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] w);
        return w[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_tag(input logic [DATA_W-1:0] w);
        return w[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/fifo_pong_reader_if.sv
// Handshake bundle between the ping-pong FIFO, the reader
// and the indication path.
interface fifo_pong_reader_if;
    import fifo_pong_reader_pkg::*;

    logic [DATA_W-1:0] src_first;
    logic              src_first__RDY;
    logic              src_deq__ENA;
    logic              src_deq__RDY;
    logic              report__ENA;
    logic              report__RDY;
    logic [LEN_W-1:0]  report_tag;
    logic [LEN_W-1:0]  report_len;
    logic [DATA_W-1:0] report_sum;
    logic              report_err;
    logic              busy;

    modport master (
        input  src_first, src_first__RDY, src_deq__RDY, report__RDY,
        output src_deq__ENA, report__ENA, report_tag, report_len,
        output report_sum, report_err, busy
    );

    modport slave (
        output src_first, src_first__RDY, src_deq__RDY, report__RDY,
        input  src_deq__ENA, report__ENA, report_tag, report_len,
        input  report_sum, report_err, busy
    );

endinterface

// File: rtl/fifo_pong_reader_frame_accumulator.sv
// Per-frame payload checksum and remaining-word counter.
// last_o flags that the word being consumed ends the frame.
module frame_accumulator
    import fifo_pong_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              add_i,
    input  logic              keep_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              last_o
);

    logic [DATA_W-1:0] sum_q, sum_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    always_comb begin
        sum_d = sum_q;
        rem_d = rem_q;
        if (load_i) begin
            sum_d = '0;
            rem_d = hdr_len(word_i);
        end else if (add_i) begin
            rem_d = rem_q - LEN_W'(1);
            if (keep_i) sum_d = sum_q + word_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            rem_q <= '0;
        end else begin
            sum_q <= sum_d;
            rem_q <= rem_d;
        end
    end

    assign sum_o  = sum_q;
    assign last_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/fifo_pong_reader.sv
// Drains length-prefixed frames from the FIFO head and issues
// one tag/len/checksum report per frame.
module fifo_pong_reader
    import fifo_pong_reader_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic CLK,
    input  logic nRST,
    fifo_pong_reader_if.master bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  tag_q, tag_d, len_q, len_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  rtag_q, rtag_d, rlen_q, rlen_d;
    logic [DATA_W-1:0] rsum_q, rsum_d;
    logic              rerr_q, rerr_d;
    logic              deq, load, add, last;
    logic [DATA_W-1:0] word, sum;

    assign word = bus.src_first;
    assign deq  = nRST && (state_q != S_RPT)
                  && bus.src_first__RDY && bus.src_deq__RDY;

    frame_accumulator u_acc (
        .clk    (CLK),
        .rst_n  (nRST),
        .load_i (load),
        .add_i  (add),
        .keep_i (!err_q),
        .word_i (word),
        .sum_o  (sum),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        len_d   = len_q;
        err_d   = err_q;
        rtag_d  = rtag_q;
        rlen_d  = rlen_q;
        rsum_d  = rsum_q;
        rerr_d  = rerr_q;
        load    = 1'b0;
        add     = 1'b0;
        unique case (state_q)
            S_HDR: if (deq) begin
                load  = 1'b1;
                tag_d = hdr_tag(word);
                len_d = hdr_len(word);
                err_d = hdr_len(word) > MAX_LEN_C;
                if (hdr_len(word) == '0) begin
                    state_d = S_RPT;
                    rtag_d  = hdr_tag(word);
                    rlen_d  = '0;
                    rsum_d  = '0;
                    rerr_d  = 1'b0;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_PAY: if (deq) begin
                add = 1'b1;
                // Report fields are captured on the final deq so they
                // are already stable when report__ENA rises.
                if (last) begin
                    state_d = S_RPT;
                    rtag_d  = tag_q;
                    rlen_d  = len_q;
                    rsum_d  = err_q ? '0 : sum + word;
                    rerr_d  = err_q;
                end
            end
            S_RPT: if (bus.report__RDY) state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_HDR;
            tag_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            rtag_q  <= '0;
            rlen_q  <= '0;
            rsum_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            len_q   <= len_d;
            err_q   <= err_d;
            rtag_q  <= rtag_d;
            rlen_q  <= rlen_d;
            rsum_q  <= rsum_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.src_deq__ENA = deq;
    assign bus.report__ENA  = (state_q == S_RPT);
    assign bus.busy         = (state_q != S_HDR);
    assign bus.report_tag   = rtag_q;
    assign bus.report_len   = rlen_q;
    assign bus.report_sum   = rsum_q;
    assign bus.report_err   = rerr_q;

endmodule
